// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-source bus arbiter.
package bus_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Round-robin pick: a lone requester wins, a tie goes to the source not granted last.
  function automatic logic pick_a(input logic req_a, input logic req_b, input logic last_b);
    return req_a && (!req_b || last_b);
  endfunction

endpackage

// File: rtl/settle_counter_k.sv
// Loadable down-counter timing the bus settle window; zero is a flag on the current count.
module settle_counter_k
  import bus_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_arbiter_k.sv
// Two-source arbiter for a shared tri-state mux: selects a source, waits for the bus to settle, captures it.
module bus_arbiter_k
  import bus_arb_pkg::*;
#(
  parameter int unsigned num_tri       = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_a,
  input  logic               req_b,
  input  logic [num_tri-1:0] bus_in,
  output logic               oe_,
  output logic               gnt_a,
  output logic               gnt_b,
  output logic [num_tri-1:0] data_out,
  output logic               data_valid
);

  state_t state;
  logic   last_b;
  logic   any_req;
  logic   win_a;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  assign any_req  = req_a || req_b;
  assign win_a    = pick_a(req_a, req_b, last_b);
  assign cnt_load = (state == IDLE) && any_req;
  assign cnt_dec  = (state == SETTLE) && !cnt_zero;

  settle_counter_k u_settle (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (CNT_W'(SETTLE_CYCLES - 1)),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      oe_        <= 1'b1;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      last_b     <= 1'b1;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state  <= SETTLE;
            oe_    <= win_a;
            gnt_a  <= win_a;
            gnt_b  <= !win_a;
            last_b <= !win_a;
          end
        end
        SETTLE: begin
          if (cnt_zero) state <= CAPTURE;
        end
        CAPTURE: begin
          data_out   <= bus_in;
          data_valid <= 1'b1;
          gnt_a      <= 1'b0;
          gnt_b      <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
